// File: rtl/dcache_write_buffer.sv
// dcache_write_buffer
//   In-order write buffer between the dcache and the cache-to-AXI bridge write port.
//   It accepts 4-word dirty-line writebacks and single-word uncached stores.
//   Entries drain one at a time through the data_wr_* handshake.
//   Each entry stays occupied until its B response (data_wr_ok) arrives.
//   A line-granular address query lets the dcache stall reads to lines still in flight.
//
// Ports
//   clk, resetn             clock, synchronous active-low reset
//   in_req/in_type/in_addr/in_size/in_wstrb/in_data
//                           dcache write request (in_type=1: 16B line)
//   in_rdy                  entry free; push = in_req & in_rdy
//   data_wr_req/type/addr/size/wstrb/data
//                           oldest not-yet-issued entry, presented to the bridge
//   data_wr_rdy             bridge accepts; issue = data_wr_req & data_wr_rdy
//   data_wr_ok              B response for the oldest issued entry
//   query_addr, query_hit   combinational line-address hazard check
//   wb_empty                no queued or in-flight entries
//
// Configuration
//   WBUF_FWD_EN  adds fwd_valid/fwd_data: the data of the youngest matching
//                entry, valid only when that entry is a full line.

module dcache_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         in_req,
    input  logic         in_type,
    input  logic [31:0]  in_addr,
    input  logic [2:0]   in_size,
    input  logic [3:0]   in_wstrb,
    input  logic [127:0] in_data,
    output logic         in_rdy,
    output logic         data_wr_req,
    output logic         data_wr_type,
    output logic [31:0]  data_wr_addr,
    output logic [2:0]   data_wr_size,
    output logic [3:0]   data_wr_wstrb,
    output logic [127:0] data_wr_data,
    input  logic         data_wr_rdy,
    input  logic         data_wr_ok,
    input  logic [31:0]  query_addr,
    output logic         query_hit,
    output logic         wb_empty
`ifdef WBUF_FWD_EN
    ,
    output logic         fwd_valid,
    output logic [127:0] fwd_data
`endif
);

    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] tail_q, tail_d;
    logic [AW:0] iss_q,  iss_d;
    logic [AW:0] head_q, head_d;

    logic         type_q  [DEPTH];
    logic [31:0]  addr_q  [DEPTH];
    logic [2:0]   size_q  [DEPTH];
    logic [3:0]   wstrb_q [DEPTH];
    logic [127:0] data_q  [DEPTH];

    logic [AW:0] occ;
    logic        full;
    logic        pending;
    logic        outstanding;
    logic        push;
    logic        issue;
    logic        retire;

    assign occ         = tail_q - head_q;
    assign full        = (occ == OCC_FULL);
    assign pending     = (tail_q != iss_q);
    assign outstanding = (iss_q != head_q);

    // in_rdy depends on registered state only: a retire this cycle frees the
    // slot for the next cycle, never the current one.
    assign in_rdy   = !full;
    assign wb_empty = (occ == '0);

    assign push   = in_req && in_rdy;
    assign issue  = pending && data_wr_rdy;
    assign retire = data_wr_ok && outstanding;

    assign data_wr_req   = pending;
    assign data_wr_type  = type_q[iss_q[AW-1:0]];
    assign data_wr_addr  = addr_q[iss_q[AW-1:0]];
    assign data_wr_size  = size_q[iss_q[AW-1:0]];
    assign data_wr_wstrb = wstrb_q[iss_q[AW-1:0]];
    assign data_wr_data  = data_q[iss_q[AW-1:0]];

    always_comb begin
        tail_d = push   ? tail_q + PTR_ONE : tail_q;
        iss_d  = issue  ? iss_q  + PTR_ONE : iss_q;
        head_d = retire ? head_q + PTR_ONE : head_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tail_q <= '0;
            iss_q  <= '0;
            head_q <= '0;
        end else begin
            tail_q <= tail_d;
            iss_q  <= iss_d;
            head_q <= head_d;
        end
    end

    // Payload is not reset; an entry is only ever read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            type_q[tail_q[AW-1:0]]  <= in_type;
            addr_q[tail_q[AW-1:0]]  <= in_addr;
            size_q[tail_q[AW-1:0]]  <= in_size;
            wstrb_q[tail_q[AW-1:0]] <= in_wstrb;
            data_q[tail_q[AW-1:0]]  <= in_data;
        end
    end

    // Walk occupied slots from oldest to youngest so the last match seen is
    // the youngest one, which is the entry whose data forwarding must use.
    logic [AW-1:0] slot;
    logic          hit;
    logic          young_type;
    logic [127:0]  young_data;

    always_comb begin
        slot       = '0;
        hit        = 1'b0;
        young_type = 1'b0;
        young_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head_q[AW-1:0] + AW'(k);
            if (((AW+1)'(k) < occ) && (addr_q[slot][31:4] == query_addr[31:4])) begin
                hit        = 1'b1;
                young_type = type_q[slot];
                young_data = data_q[slot];
            end
        end
    end

    assign query_hit = hit;

`ifdef WBUF_FWD_EN
    assign fwd_valid = hit && young_type;
    assign fwd_data  = young_data;
`else
    logic unused_fwd;
    assign unused_fwd = &{1'b0, young_type, young_data};
`endif

    logic unused_query;
    assign unused_query = &{1'b0, query_addr[3:0]};

endmodule

// File: tb/tb_dcache_write_buffer.sv
module tb_dcache_write_buffer;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         resetn;
    logic         in_req;
    logic         in_type;
    logic [31:0]  in_addr;
    logic [2:0]   in_size;
    logic [3:0]   in_wstrb;
    logic [127:0] in_data;
    logic         in_rdy;
    logic         data_wr_req;
    logic         data_wr_type;
    logic [31:0]  data_wr_addr;
    logic [2:0]   data_wr_size;
    logic [3:0]   data_wr_wstrb;
    logic [127:0] data_wr_data;
    logic         data_wr_rdy;
    logic         data_wr_ok;
    logic [31:0]  query_addr;
    logic         query_hit;
    logic         wb_empty;
`ifdef WBUF_FWD_EN
    logic         fwd_valid;
    logic [127:0] fwd_data;
`endif

    always #5 clk = ~clk;

    dcache_write_buffer #(.DEPTH(4), .AW(2)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .in_req       (in_req),
        .in_type      (in_type),
        .in_addr      (in_addr),
        .in_size      (in_size),
        .in_wstrb     (in_wstrb),
        .in_data      (in_data),
        .in_rdy       (in_rdy),
        .data_wr_req  (data_wr_req),
        .data_wr_type (data_wr_type),
        .data_wr_addr (data_wr_addr),
        .data_wr_size (data_wr_size),
        .data_wr_wstrb(data_wr_wstrb),
        .data_wr_data (data_wr_data),
        .data_wr_rdy  (data_wr_rdy),
        .data_wr_ok   (data_wr_ok),
        .query_addr   (query_addr),
        .query_hit    (query_hit),
        .wb_empty     (wb_empty)
`ifdef WBUF_FWD_EN
        ,
        .fwd_valid    (fwd_valid),
        .fwd_data     (fwd_data)
`endif
    );

    typedef struct packed {
        logic         typ;
        logic [31:0]  addr;
        logic [2:0]   size;
        logic [3:0]   wstrb;
        logic [127:0] data;
    } ent_t;

    // Reference: entries waiting to be issued, and issued entries awaiting ok.
    ent_t q_wait[$];
    ent_t q_out[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic int m_total();
        return q_wait.size() + q_out.size();
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        foreach (q_out[i])  if (q_out[i].addr[31:4]  == a[31:4]) return 1'b1;
        foreach (q_wait[i]) if (q_wait[i].addr[31:4] == a[31:4]) return 1'b1;
        return 1'b0;
    endfunction

    // Youngest matching entry: search the waiting queue from its back, then the issued one.
    function automatic ent_t m_youngest(input logic [31:0] a);
        ent_t e;
        e = '0;
        for (int i = q_wait.size() - 1; i >= 0; i--)
            if (q_wait[i].addr[31:4] == a[31:4]) return q_wait[i];
        for (int i = q_out.size() - 1; i >= 0; i--)
            if (q_out[i].addr[31:4] == a[31:4]) return q_out[i];
        return e;
    endfunction

    task automatic model_step();
        bit   do_push;
        bit   do_iss;
        bit   do_ret;
        ent_t e;
        if (!resetn) begin
            q_wait.delete();
            q_out.delete();
            return;
        end
        do_push = in_req && (m_total() < DEPTH);
        do_iss  = (q_wait.size() > 0) && data_wr_rdy;
        do_ret  = data_wr_ok && (q_out.size() > 0);
        if (do_ret) void'(q_out.pop_front());
        if (do_iss) q_out.push_back(q_wait.pop_front());
        if (do_push) begin
            e.typ   = in_type;
            e.addr  = in_addr;
            e.size  = in_size;
            e.wstrb = in_wstrb;
            e.data  = in_data;
            q_wait.push_back(e);
        end
    endtask

    task automatic check_all();
        chk("in_rdy",      in_rdy,      m_total() < DEPTH);
        chk("data_wr_req", data_wr_req, q_wait.size() > 0);
        chk("wb_empty",    wb_empty,    m_total() == 0);
        chk("query_hit",   query_hit,   m_hit(query_addr));
        if (q_wait.size() > 0) begin
            chk("wr_type",  data_wr_type,  q_wait[0].typ);
            chk("wr_addr",  data_wr_addr,  q_wait[0].addr);
            chk("wr_size",  data_wr_size,  q_wait[0].size);
            chk("wr_wstrb", data_wr_wstrb, q_wait[0].wstrb);
            chk("wr_data",  data_wr_data,  q_wait[0].data);
        end
`ifdef WBUF_FWD_EN
        begin
            ent_t y;
            y = m_youngest(query_addr);
            chk("fwd_valid", fwd_valid, m_hit(query_addr) && y.typ);
            if (m_hit(query_addr) && y.typ) chk("fwd_data", fwd_data, y.data);
        end
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic set_push(input logic req, input logic typ, input logic [31:0] addr,
                            input logic [127:0] data);
        in_req   = req;
        in_type  = typ;
        in_addr  = addr;
        in_data  = data;
        in_size  = typ ? 3'd4 : 3'd2;
        in_wstrb = typ ? 4'hf : 4'($urandom_range(1, 15));
    endtask

    task automatic do_reset();
        resetn      = 1'b0;
        in_req      = 1'b0;
        data_wr_rdy = 1'b0;
        data_wr_ok  = 1'b0;
        cycle();
        cycle();
        resetn = 1'b1;
    endtask

    logic [127:0] dat_a;
    logic [127:0] dat_b;

    initial begin
        resetn      = 1'b0;
        data_wr_rdy = 1'b0;
        data_wr_ok  = 1'b0;
        query_addr  = 32'h0000_1230;
        set_push(1'b0, 1'b0, 32'h0, '0);
        #1;

        // Reset values
        do_reset();
        chk("rst_in_rdy",    in_rdy,      1'b1);
        chk("rst_wr_req",    data_wr_req, 1'b0);
        chk("rst_wb_empty",  wb_empty,    1'b1);
        chk("rst_query_hit", query_hit,   1'b0);

        // Single line writeback
        data_wr_rdy = 1'b1;
        set_push(1'b1, 1'b1, 32'h1fc0_0040, rnd128());
        cycle();
        set_push(1'b0, 1'b0, 32'h0, '0);
        chk("wb_req",  data_wr_req,  1'b1);
        chk("wb_addr", data_wr_addr, 32'h1fc0_0040);
        cycle();
        chk("wb_req_after_issue", data_wr_req, 1'b0);
        chk("wb_not_empty", wb_empty, 1'b0);
        data_wr_rdy = 1'b0;
        cycle();
        chk("wb_still_busy", wb_empty, 1'b0);
        data_wr_ok = 1'b1;
        cycle();
        data_wr_ok = 1'b0;
        chk("wb_empty_after_ok", wb_empty, 1'b1);

        // Fill to full, then one issue + ok with a push attempt while still full
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_push(1'b1, 1'($urandom_range(0, 1)), 32'h0000_2000 + 32'(i * 16), rnd128());
            cycle();
        end
        chk("full_in_rdy", in_rdy, 1'b0);
        set_push(1'b0, 1'b0, 32'h0, '0);
        data_wr_rdy = 1'b1;
        cycle();
        data_wr_rdy = 1'b0;
        data_wr_ok  = 1'b1;
        set_push(1'b1, 1'b1, 32'h0000_3000, rnd128());
        cycle();
        data_wr_ok = 1'b0;
        set_push(1'b0, 1'b0, 32'h0, '0);
        chk("full_retire_in_rdy", in_rdy, 1'b1);
        chk("full_order_addr", data_wr_addr, 32'h0000_2010);
        data_wr_rdy = 1'b1;
        data_wr_ok  = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        data_wr_rdy = 1'b0;
        data_wr_ok  = 1'b0;
        chk("drain_empty", wb_empty, 1'b1);

        // Hazard query against an outstanding entry
        do_reset();
        data_wr_rdy = 1'b1;
        set_push(1'b1, 1'b0, 32'h0000_1230, rnd128());
        cycle();
        set_push(1'b0, 1'b0, 32'h0, '0);
        cycle();
        data_wr_rdy = 1'b0;
        query_addr = 32'h0000_123c;
        #1 chk("haz_same_line", query_hit, 1'b1);
        query_addr = 32'h0000_1240;
        #1 chk("haz_next_line", query_hit, 1'b0);
        data_wr_ok = 1'b1;
        cycle();
        data_wr_ok = 1'b0;
        query_addr = 32'h0000_123c;
        #1 chk("haz_after_ok", query_hit, 1'b0);

        // Push, issue and retire in one cycle
        do_reset();
        set_push(1'b1, 1'b0, 32'h0000_4000, rnd128());
        cycle();
        data_wr_rdy = 1'b1;
        set_push(1'b1, 1'b0, 32'h0000_4010, rnd128());
        cycle();
        data_wr_ok = 1'b1;
        set_push(1'b1, 1'b1, 32'h0000_4020, rnd128());
        cycle();
        data_wr_ok  = 1'b0;
        data_wr_rdy = 1'b0;
        set_push(1'b0, 1'b0, 32'h0, '0);
        chk("sim_wr_addr", data_wr_addr, 32'h0000_4020);
        chk("sim_in_rdy",  in_rdy,       1'b1);

        // Spurious ok while nothing is outstanding
        do_reset();
        set_push(1'b1, 1'b0, 32'h0000_5000, rnd128());
        cycle();
        set_push(1'b0, 1'b0, 32'h0, '0);
        data_wr_ok = 1'b1;
        cycle();
        data_wr_ok = 1'b0;
        chk("spur_req",   data_wr_req, 1'b1);
        chk("spur_empty", wb_empty,    1'b0);

`ifdef WBUF_FWD_EN
        // Forwarding picks the youngest line entry
        do_reset();
        dat_a = rnd128();
        dat_b = rnd128();
        set_push(1'b1, 1'b1, 32'h0000_6000, dat_a);
        cycle();
        set_push(1'b1, 1'b1, 32'h0000_6000, dat_b);
        cycle();
        set_push(1'b0, 1'b0, 32'h0, '0);
        query_addr = 32'h0000_6008;
        #1;
        chk("fwd_valid_b", fwd_valid, 1'b1);
        chk("fwd_data_b",  fwd_data,  dat_b);
`else
        dat_a = '0;
        dat_b = '0;
`endif

        // Randomized traffic, including occasional mid-operation reset
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            set_push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     32'h0000_1000 | (32'($urandom_range(0, 7)) << 4) | (32'($urandom_range(0, 3)) << 2),
                     rnd128());
            data_wr_rdy = 1'($urandom_range(0, 1));
            data_wr_ok  = ($urandom_range(0, 9) < 4);
            query_addr  = 32'h0000_1000 | (32'($urandom_range(0, 7)) << 4) | 32'($urandom_range(0, 15));
            resetn      = ($urandom_range(0, 299) != 0);
            cycle();
        end
        resetn = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
